switch_debouncer: RTL
=====================

Name: switch_debouncer

Overview:
- Upstream input stage for the LED decoder; cleans the raw DIP-switch bus before it reaches the decoder's s input.
- Each bit is synchronised into clk with two flops, then debounced by a per-bit stability counter.
- Outputs are a glitch-free s_clean bus plus one-cycle per-bit rise/fall pulses and an aggregate changed strobe, for downstream logic and the bench.

Parameters:
- WIDTH, 4, number of switch bits.
- STABLE_CYCLES, 480000, consecutive mismatching cycles required before a bit is accepted (10 ms at 48 MHz). Legal range is ≥ 2; elaboration fails otherwise.
- CNT_W, $clog2(STABLE_CYCLES), counter width. Derived; not overridden by users.

Ports:
- clk  input  1  system clock, rising-edge only.
- reset  input  1  synchronous, active-high reset.
- s_raw  input  WIDTH  asynchronous switch levels.
- s_clean  output  WIDTH  debounced switch levels; feeds the LED decoder s input.
- rise  output  WIDTH  one-cycle pulse per bit when s_clean bit goes 0→1.
- fall  output  WIDTH  one-cycle pulse per bit when s_clean bit goes 1→0.
- changed  output  1  OR of rise|fall, registered in the same cycle as the pulses.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset. No asynchronous reset anywhere.
- Reset (sampled at a rising edge with reset=1):
  - sync1, sync2, s_clean, every counter, rise, fall and changed all go to 0.
  - Reset mid-count discards partial counts.
  - Reset has priority over every other update in the same cycle.
- Synchroniser: sync1 <= s_raw, then sync2 <= sync1. No logic between the two flops.
- Per-bit update at each edge, with mismatch = sync2[i] != s_clean[i]:
  - mismatch and cnt == STABLE_CYCLES-1: s_clean[i] <= sync2[i]; cnt <= 0; rise[i] or fall[i] <= 1 per direction.
  - mismatch and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - no mismatch: cnt <= 0.
- Pulses: rise, fall and changed are registered and default to 0 every cycle. They are high for exactly one cycle.
- Latency: if s_raw changes between edge 0 and edge 1 and then holds, s_clean updates at edge STABLE_CYCLES+2, with pulses in the same cycle.
- Glitch rejection: a bounce that leaves sync2 mismatched for fewer than STABLE_CYCLES consecutive edges never reaches s_clean. Any cycle without a mismatch restarts that bit's count from 0.
- Bits are fully independent. Several bits may update in the same cycle; their rise/fall bits assert together and changed asserts once.
- Post-reset with s_raw held nonzero: bits ramp from the reset value 0. Each such bit produces a rise pulse at edge STABLE_CYCLES+2 after reset deasserts. This is intended.
- Counter width: counters saturate logically at STABLE_CYCLES-1 and never wrap, because a mismatch at the top count always clears to 0.

Decomposition:
- Package switch_pkg holds:
  - localparam SW_WIDTH = 4
  - localparam DEBOUNCE_CYCLES_HW = 480000
  - localparam DEBOUNCE_CYCLES_SIM = 4
  - typedef logic [SW_WIDTH-1:0] sw_t
- One sub-module, debounce_bit. It contains one bit's synchroniser, counter, s_clean bit and rise/fall pulse logic, parameterised by STABLE_CYCLES.
- switch_debouncer generates WIDTH instances of debounce_bit and ORs the pulses into changed.

Test Plan (all with STABLE_CYCLES=4, WIDTH=4):
- Reset: hold reset 3 cycles with s_raw=4'b1111 → s_clean=0000, rise=fall=0000, changed=0 throughout reset. Release reset → rise=1111 and s_clean=1111 at edge 6 after release, single-cycle pulse.
- Clean step: from s_clean=0000, set s_raw=4'b0101 before edge 1 → s_clean=0000 through edge 5, becomes 0101 at edge 6. rise=0101 and changed=1 for that one cycle only.
- Bounce rejection: toggle s_raw[2] 0→1→0 with 1-cycle and then 3-cycle high pulses → s_clean stays 0000, rise/fall/changed never assert.
- Bounce then settle: s_raw[0] toggles every cycle for 6 cycles then holds 1 → s_clean[0] rises exactly 6 edges after the last transition is sampled, with one rise[0] pulse.
- Simultaneous opposite edges: s_clean=1100, apply s_raw=0011 → at edge 6, s_clean=0011, rise=0011, fall=1100, changed=1 for one cycle.
- Reset mid-count: s_raw=0001 applied, assert reset at edge 3 for 1 cycle → no rise pulse at edge 6. s_clean[0] rises 6 edges after reset deasserts.

Source files
------------

// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared widths and debounce periods for the switch input stage
package switch_pkg;

    localparam int SW_WIDTH            = 4;
    localparam int DEBOUNCE_CYCLES_HW  = 480000;
    localparam int DEBOUNCE_CYCLES_SIM = 4;

    typedef logic [SW_WIDTH-1:0] sw_t;

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - one switch bit: two-flop synchroniser, stability counter, edge pulses
module debounce_bit
    import switch_pkg::*;
#(
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_HW
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic fire
);

    if (STABLE_CYCLES < 2) begin : g_bad_stable_cycles
        $error("debounce_bit: STABLE_CYCLES must be at least 2");
    end

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             mismatch;

    assign mismatch = (sync2 != clean);
    // fire is the cycle whose edge commits sync2 into clean; the top registers changed from it
    assign fire     = mismatch && (cnt == CNT_TOP);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            clean <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            if (fire) begin
                clean <= sync2;
                cnt   <= '0;
                rise  <= sync2;
                fall  <= ~sync2;
            end else if (mismatch) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - debounces the DIP-switch bus feeding the LED decoder
module switch_debouncer
    import switch_pkg::*;
#(
    parameter int WIDTH         = SW_WIDTH,
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_HW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_raw,
    output logic [WIDTH-1:0] s_clean,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    logic [WIDTH-1:0] fire;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_bit (
            .clk  (clk),
            .reset(reset),
            .raw  (s_raw[i]),
            .clean(s_clean[i]),
            .rise (rise[i]),
            .fall (fall[i]),
            .fire (fire[i])
        );
    end

    // registered from the same commit condition as the pulses so it lines up with them
    always_ff @(posedge clk) begin
        if (reset) begin
            changed <= 1'b0;
        end else begin
            changed <= |fire;
        end
    end

endmodule
